turn_timer: RTL and testbench
=============================

Name: turn_timer

Overview:
Per-turn countdown timer for the game controller, counting in the opposite direction to the free-running up-counters used for display refresh. A start pulse loads the seconds budget. An internal prescaler derives 1 s ticks from clk, and secs_left counts down to zero. On reaching zero the block raises expired and a one-cycle expire_pulse, which the game FSM uses to forfeit the turn. BCD digits are also output for the 7-segment display.

Parameters:
TICK_DIV, 100_000_000, clk cycles per second tick (set to 4 in simulation)
SEC_BITS, 7, width of the seconds count
MAX_SEC, 99, clamp ceiling for load_val (must be <= 99 and < 2**SEC_BITS)
WARN_SEC, 5, warn asserts while running and secs_left <= WARN_SEC

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  pulse: load load_val and run (also a restart when already running)
clear  in  1  pulse: abort and return to IDLE
pause  in  1  level: freeze prescaler and count while RUN
load_val  in  SEC_BITS  seconds budget, sampled on the start cycle
secs_left  out  SEC_BITS  remaining seconds
bcd_tens  out  4  tens digit of secs_left
bcd_ones  out  4  ones digit of secs_left
running  out  1  high in RUN (including while paused)
expired  out  1  level, high in EXPIRED
expire_pulse  out  1  one-cycle strobe on entry to EXPIRED
warn  out  1  low-time indicator

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk. All state updates occur on the rising edge of clk.
- Reset values: state IDLE, prescaler 0, secs_left 0, running 0, expired 0, expire_pulse 0, warn 0, bcd_tens 0, bcd_ones 0.
- States: IDLE, RUN, EXPIRED. All outputs are registered except the BCD digits, which are combinational from registered secs_left.
- Load clamp: eff = min(load_val, MAX_SEC).
- Priority per cycle: clear > start > tick.
- IDLE:
  - start with eff > 0 -> RUN next cycle; secs_left = eff; prescaler = 0.
  - start with eff = 0 -> EXPIRED next cycle; expire_pulse = 1 that cycle.
- RUN:
  - pause = 1: prescaler and secs_left hold.
  - pause = 0: prescaler increments. When prescaler == TICK_DIV-1, prescaler wraps to 0 and secs_left decrements.
  - Result: the first decrement is visible exactly TICK_DIV cycles after running first asserts (with no pause).
  - Decrement from 1 to 0 -> EXPIRED; secs_left = 0; expire_pulse = 1 in that same registered cycle.
  - start in RUN -> reload eff, prescaler = 0, stay in RUN (restart). A start on the same cycle as the final tick wins over expiry.
- EXPIRED:
  - expired holds high; expire_pulse lasts exactly one cycle.
  - start reloads as from IDLE.
  - clear -> IDLE; secs_left = 0.
- clear in any state -> IDLE next cycle; prescaler = 0; secs_left = 0; no expire_pulse.
- warn = running && secs_left <= WARN_SEC. warn is never asserted in IDLE or EXPIRED.
- Async rst mid-count returns everything to reset values immediately; no expire_pulse is generated.
- Widths:
  - Prescaler width is clog2(TICK_DIV).
  - Decrement uses SEC_BITS arithmetic; underflow cannot occur because the 1->0 decrement exits RUN.

Decomposition:
- Shared game package:
  - timer state enum (IDLE, RUN, EXPIRED);
  - default TICK_DIV constants for synthesis and simulation;
  - MAX_SEC.
- One sub-module: bin2bcd. Combinational binary-to-two-digit BCD (0..99), reused by the score display.

Test Plan:
- TICK_DIV=4, load_val=3, start -> running=1 next cycle; secs_left 3,2,1 at 4-cycle steps; secs_left 0, expired=1, expire_pulse=1 for one cycle exactly 12 cycles after running rose.
- load_val=120, start -> secs_left=99, bcd_tens=9, bcd_ones=9; load_val=0, start -> EXPIRED next cycle with a single expire_pulse.
- load_val=5, run 6 cycles, hold pause for 10 cycles -> secs_left stays 4; release pause -> next decrement 2 cycles later.
- Running at secs_left=2, assert start with load_val=7 on a tick cycle -> secs_left=7, prescaler restarted; start and clear in the same cycle -> IDLE, secs_left=0.
- WARN_SEC=5, load_val=7 -> warn rises when secs_left=5 and falls on entry to EXPIRED.
- Assert rst asynchronously mid-count -> all outputs 0 before the next edge; no expire_pulse observed.

Source files
------------

// File: rtl/turn_timer_pkg.sv
// Shared game-controller definitions: timer state encoding and default timing constants.
package turn_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_e;

  localparam int unsigned TICK_DIV_SYN = 100_000_000;
  localparam int unsigned TICK_DIV_SIM = 4;
  localparam int unsigned SEC_BITS_DEF = 7;
  localparam int unsigned MAX_SEC      = 99;
  localparam int unsigned WARN_SEC_DEF = 5;

endpackage

// File: rtl/bin2bcd.sv
// Combinational binary (0..99) to two-digit BCD converter, shared with the score display.
module bin2bcd #(
  parameter int unsigned W = 7
) (
  input  logic [W-1:0] bin,
  output logic [3:0]   tens,
  output logic [3:0]   ones
);

  logic [W-1:0] tens_w;
  logic [W-1:0] ones_w;

  always_comb begin
    tens_w = W'(bin / W'(10));
    ones_w = W'(bin - W'(tens_w * W'(10)));
    tens   = 4'(tens_w);
    ones   = 4'(ones_w);
  end

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown timer: loads a clamped seconds budget, counts down on prescaled
// 1 s ticks and flags expiry for the game FSM; BCD digits feed the 7-segment display.
module turn_timer
  import turn_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_SYN,
  parameter int unsigned SEC_BITS = SEC_BITS_DEF,
  parameter int unsigned MAX_SEC  = turn_timer_pkg::MAX_SEC,
  parameter int unsigned WARN_SEC = WARN_SEC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                clear,
  input  logic                pause,
  input  logic [SEC_BITS-1:0] load_val,
  output logic [SEC_BITS-1:0] secs_left,
  output logic [3:0]          bcd_tens,
  output logic [3:0]          bcd_ones,
  output logic                running,
  output logic                expired,
  output logic                expire_pulse,
  output logic                warn
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  timer_state_e        state, state_nx;
  logic [PW-1:0]       presc, presc_nx;
  logic [SEC_BITS-1:0] secs_nx;
  logic [SEC_BITS-1:0] eff;
  logic                pulse_nx;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      presc        <= '0;
      secs_left    <= '0;
      running      <= 1'b0;
      expired      <= 1'b0;
      expire_pulse <= 1'b0;
      warn         <= 1'b0;
    end else begin
      state        <= state_nx;
      presc        <= presc_nx;
      secs_left    <= secs_nx;
      running      <= (state_nx == RUN);
      expired      <= (state_nx == EXPIRED);
      expire_pulse <= pulse_nx;
      warn         <= (state_nx == RUN) && (secs_nx <= SEC_BITS'(WARN_SEC));
    end
  end

  // Next state: clear beats start, start beats the tick
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    secs_nx  = secs_left;
    pulse_nx = 1'b0;
    eff      = (load_val > SEC_BITS'(MAX_SEC)) ? SEC_BITS'(MAX_SEC) : load_val;

    if (clear) begin
      state_nx = IDLE;
      presc_nx = '0;
      secs_nx  = '0;
    end else if (start) begin
      presc_nx = '0;
      if (eff == '0) begin
        state_nx = EXPIRED;
        secs_nx  = '0;
        pulse_nx = 1'b1;
      end else begin
        state_nx = RUN;
        secs_nx  = eff;
      end
    end else if (state == RUN && !pause) begin
      if (presc == PW'(TICK_DIV - 1)) begin
        presc_nx = '0;
        // The 1->0 step leaves RUN, so the count never underflows
        if (secs_left == SEC_BITS'(1)) begin
          state_nx = EXPIRED;
          secs_nx  = '0;
          pulse_nx = 1'b1;
        end else begin
          secs_nx = secs_left - SEC_BITS'(1);
        end
      end else begin
        presc_nx = presc + PW'(1);
      end
    end
  end

  bin2bcd #(.W(SEC_BITS)) u_bcd (
    .bin  (secs_left),
    .tens (bcd_tens),
    .ones (bcd_ones)
  );

endmodule

// File: tb/tb_turn_timer.sv
// Directed self-checking bench for turn_timer with a 4-cycle simulation tick.
module tb_turn_timer;
  import turn_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, clear, pause;
  logic [6:0] load_val;
  logic [6:0] secs_left;
  logic [3:0] bcd_tens, bcd_ones;
  logic       running, expired, expire_pulse, warn;

  int total = 0;
  int bad   = 0;

  turn_timer #(.TICK_DIV(TICK_DIV_SIM), .SEC_BITS(7), .MAX_SEC(99), .WARN_SEC(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .clear        (clear),
    .pause        (pause),
    .load_val     (load_val),
    .secs_left    (secs_left),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones),
    .running      (running),
    .expired      (expired),
    .expire_pulse (expire_pulse),
    .warn         (warn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit after the last edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [6:0] v);
    load_val = v;
    start    = 1'b1;
    step(1);
    start    = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; pause = 1'b0; load_val = '0;
    #12;
    chk("rst_secs", 32'(secs_left), 0);
    chk("rst_flags", {28'd0, running, expired, expire_pulse, warn}, 0);
    chk("rst_bcd", {24'd0, bcd_tens, bcd_ones}, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // Basic countdown from 3
    pulse_start(7'd3);
    chk("run_rise", 32'(running), 1);
    chk("load3", 32'(secs_left), 3);
    chk("warn_at3", 32'(warn), 1);
    step(3);
    chk("hold3", 32'(secs_left), 3);
    step(1);
    chk("dec2", 32'(secs_left), 2);
    step(4);
    chk("dec1", 32'(secs_left), 1);
    step(3);
    chk("pre_exp", 32'(expired), 0);
    step(1);
    chk("exp_secs", 32'(secs_left), 0);
    chk("exp_flags", {29'd0, running, expired, expire_pulse}, 3'b011);
    chk("exp_warn", 32'(warn), 0);
    step(1);
    chk("pulse_once", {30'd0, expired, expire_pulse}, 2'b10);

    // Clear, clamp and BCD
    pulse_clear();
    chk("clr_flags", {29'd0, running, expired, expire_pulse}, 0);
    chk("clr_secs", 32'(secs_left), 0);
    pulse_start(7'd120);
    chk("clamp", 32'(secs_left), 99);
    chk("bcd99", {24'd0, bcd_tens, bcd_ones}, 32'h99);
    chk("warn99", 32'(warn), 0);
    pulse_start(7'd57);
    chk("bcd57", {24'd0, bcd_tens, bcd_ones}, 32'h57);

    // Zero budget expires immediately
    pulse_clear();
    pulse_start(7'd0);
    chk("zero_flags", {29'd0, running, expired, expire_pulse}, 3'b011);
    chk("zero_secs", 32'(secs_left), 0);
    step(1);
    chk("zero_pulse1", {30'd0, expired, expire_pulse}, 2'b10);

    // Pause freezes prescaler and count
    pulse_clear();
    pulse_start(7'd5);
    chk("warn5", 32'(warn), 1);
    step(6);
    chk("p_pre", 32'(secs_left), 4);
    pause = 1'b1;
    step(10);
    chk("p_hold", 32'(secs_left), 4);
    chk("p_run", 32'(running), 1);
    pause = 1'b0;
    step(1);
    chk("p_rel1", 32'(secs_left), 4);
    step(1);
    chk("p_rel2", 32'(secs_left), 3);

    // Restart on a tick cycle wins over the decrement
    step(4);
    chk("at2", 32'(secs_left), 2);
    step(3);
    pulse_start(7'd7);
    chk("restart", 32'(secs_left), 7);
    chk("bcd7", {24'd0, bcd_tens, bcd_ones}, 32'h07);
    chk("warn7", 32'(warn), 0);
    step(3);
    chk("rs_hold", 32'(secs_left), 7);
    step(1);
    chk("rs_dec", 32'(secs_left), 6);
    chk("warn6", 32'(warn), 0);
    step(4);
    chk("warn_rise", {25'd0, secs_left, warn}, {25'd0, 7'd5, 1'b1});
    step(16);
    chk("at1", {25'd0, secs_left, warn}, {25'd0, 7'd1, 1'b1});
    step(4);
    chk("warn_fall", {29'd0, expired, expire_pulse, warn}, 3'b110);

    // Start and clear together: clear wins
    clear = 1'b1;
    pulse_start(7'd9);
    clear = 1'b0;
    chk("sc_flags", {29'd0, running, expired, expire_pulse}, 0);
    chk("sc_secs", 32'(secs_left), 0);

    // Start on the final tick wins over expiry
    pulse_start(7'd1);
    step(3);
    pulse_start(7'd2);
    chk("fin_start", {25'd0, secs_left, running, expire_pulse}, {25'd0, 7'd2, 2'b10});
    chk("fin_exp", 32'(expired), 0);

    // Asynchronous reset mid-count
    step(2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_secs", 32'(secs_left), 0);
    chk("arst_flags", {28'd0, running, expired, expire_pulse, warn}, 0);
    step(2);
    @(negedge clk);
    rst = 1'b0;
    step(8);
    chk("arst_after", {29'd0, running, expired, expire_pulse}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
